// File: rtl/divider_unit_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default width.
package divider_unit_pkg;

  localparam int unsigned DIV_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_unit_trial_subtractor.sv
// DIV_W+1-bit ripple-borrow trial subtractor; carry-out high means minuend >= subtrahend.
module trial_subtractor #(
  parameter int unsigned DIV_W = 4
) (
  input  logic [DIV_W:0] minuend,
  input  logic [DIV_W:0] subtrahend,
  output logic [DIV_W:0] difference,
  output logic           non_negative
);

  logic [DIV_W+1:0] carry;

  // a - b computed as a + ~b + 1, one full adder per bit
  always_comb begin
    carry      = '0;
    carry[0]   = 1'b1;
    difference = '0;
    for (int unsigned i = 0; i <= DIV_W; i++) begin
      difference[i] = minuend[i] ^ ~subtrahend[i] ^ carry[i];
      carry[i+1]    = (minuend[i] & ~subtrahend[i]) |
                      (carry[i] & (minuend[i] ^ ~subtrahend[i]));
    end
    non_negative = carry[DIV_W+1];
  end

endmodule

// File: rtl/divider_unit.sv
// Multi-cycle restoring unsigned divider: one quotient bit per RUN cycle, DIV_W cycles per result.
module divider_unit
  import divider_unit_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(DIV_W) + 1;

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W:0]   part_rem;
  logic [DIV_W-1:0] work_quo;
  logic [DIV_W-1:0] dvs;
  logic [DIV_W:0]   shifted;
  logic [DIV_W:0]   diff;
  logic [DIV_W:0]   rem_next;
  logic [DIV_W-1:0] quo_next;
  logic             non_neg;
  logic             last_step;

  // {rem,quo} shifted left as one register pair
  assign shifted   = (part_rem << 1) | {{DIV_W{1'b0}}, work_quo[DIV_W-1]};
  assign rem_next  = non_neg ? diff : shifted;
  assign quo_next  = {work_quo[DIV_W-2:0], non_neg};
  assign last_step = (cnt == CNT_W'(DIV_W - 1));

  trial_subtractor #(.DIV_W(DIV_W)) u_trial (
    .minuend      (shifted),
    .subtrahend   ({1'b0, dvs}),
    .difference   (diff),
    .non_negative (non_neg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      part_rem    <= '0;
      work_quo    <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              work_quo    <= dividend;
              dvs         <= divisor;
              part_rem    <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          part_rem <= rem_next;
          work_quo <= quo_next;
          cnt      <= cnt + 1'b1;
          if (last_step) begin
            quotient  <= quo_next;
            remainder <= rem_next[DIV_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed table, corner sequences, random and exhaustive pairs.
module tb_divider_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  divider_unit #(.DIV_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: plain integer division, all-ones quotient on zero divisor
  task automatic model(input logic [3:0] a, input logic [3:0] b,
                       output logic [3:0] q, output logic [3:0] r, output logic z);
    int unsigned ai, bi;
    ai = a;
    bi = b;
    if (bi == 0) begin
      q = 4'hF;
      r = a;
      z = 1'b1;
    end else begin
      q = 4'(ai / bi);
      r = 4'(ai % bi);
      z = 1'b0;
    end
  endtask

  // Called #1 after an edge with the DUT in IDLE; leaves it back in IDLE
  task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er, input logic ez,
                         input string tag);
    int unsigned lat;
    logic        busy_ok;
    logic        got;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    lat      = 0;
    busy_ok  = 1'b1;
    got      = 1'b0;
    while (!got && lat < 20) begin
      if (done === 1'b1) got = 1'b1;
      else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
    check($sformatf("%s_done_seen", tag), 32'(got), 32'd1);
    check($sformatf("%s_latency", tag), lat, ez ? 32'd0 : 32'd4);
    check($sformatf("%s_busy", tag), 32'(busy_ok), 32'd1);
    check($sformatf("%s_q", tag), 32'(quotient), 32'(eq));
    check($sformatf("%s_r", tag), 32'(remainder), 32'(er));
    check($sformatf("%s_dbz", tag), 32'(div_by_zero), 32'(ez));
    @(posedge clk); #1;
    check($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
    check($sformatf("%s_q_hold", tag), 32'(quotient), 32'(eq));
    check($sformatf("%s_r_hold", tag), 32'(remainder), 32'(er));
  endtask

  initial begin
    vec_t       tbl [6];
    logic [3:0] mq, mr, ra, rb;
    logic       mz, seen;
    int unsigned cycles;

    tbl[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, z: 1'b0};
    tbl[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
    tbl[2] = '{a: 4'd2,  b: 4'd9,  q: 4'd0,  r: 4'd2, z: 1'b0};
    tbl[3] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, z: 1'b0};
    tbl[4] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
    tbl[5] = '{a: 4'd7,  b: 4'd0,  q: 4'hF,  r: 4'd7, z: 1'b1};

    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 4'd5;
    divisor  = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", 32'(quotient), 32'd0);
    check("reset_r", 32'(remainder), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, $sformatf("tbl%0d", i));

    // start while busy and held through the DONE cycle is never queued
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; dividend = 4'd14; divisor = 4'd7;
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("busy_start_done_seen", 32'(done), 32'd1);
    check("busy_start_q", 32'(quotient), 32'd4);
    check("busy_start_r", 32'(remainder), 32'd1);
    check("busy_start_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_not_accepted", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("busy_start_idle", 32'(busy), 32'd0);

    // reset at the second RUN edge aborts with no done pulse
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    check("rst_run_q", 32'(quotient), 32'd0);
    check("rst_run_r", 32'(remainder), 32'd0);
    check("rst_run_busy", 32'(busy), 32'd0);
    check("rst_run_done", 32'(done), 32'd0);
    check("rst_run_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1;
    check("rst_start_ignored", 32'(busy), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    seen  = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    check("rst_no_done", 32'(seen), 32'd0);
    run_div(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, "rst_rerun");

    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom_range(0, 15));
      model(ra, rb, mq, mr, mz);
      run_div(ra, rb, mq, mr, mz, $sformatf("rnd_%0d_%0d", ra, rb));
    end

    for (int unsigned a = 0; a < 16; a++) begin
      for (int unsigned b = 0; b < 16; b++) begin
        model(4'(a), 4'(b), mq, mr, mz);
        run_div(4'(a), 4'(b), mq, mr, mz, $sformatf("exh_%0d_%0d", a, b));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 Parameter: DIV_W, default 4, operand/result width in bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  request a division; sampled only in IDLE.
REQ-006 dividend  input  DIV_W  unsigned dividend, captured with start.
REQ-007 divisor  input  DIV_W  unsigned divisor, captured with start.
REQ-008 quotient  output  DIV_W  unsigned quotient, registered.
REQ-009 remainder  output  DIV_W  unsigned remainder, registered.
REQ-010 busy  output  1  high while a division is in progress (RUN).
REQ-011 done  output  1  one-cycle pulse; quotient/remainder/div_by_zero valid.
REQ-012 div_by_zero  output  1  set when the captured divisor was 0; valid with done.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE, with an iteration counter of width clog2(DIV_W)+1.
REQ-014 IDLE, start=1, divisor!=0 at edge k: latch operands, clear partial remainder and counter, go to RUN; busy=1 from k.
REQ-015 IDLE, start=1, divisor=0 at edge k: go to DONE; quotient=all ones, remainder=dividend, div_by_zero=1.
REQ-016 RUN SHALL perform one restoring step per cycle: shift {rem,quo} left one bit, trial-subtract divisor from DIV_W+1-bit partial remainder, keep the difference and set quotient LSB=1 if non-negative, else restore and set LSB=0.
REQ-017 After exactly DIV_W RUN cycles (edges k+1..k+DIV_W), go to DONE; done=1 and busy=0 for the cycle after edge k+DIV_W.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-019 start SHALL be ignored in RUN and DONE; no queuing.
REQ-020 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next accepted start.
REQ-021 An accepted non-zero-divisor start SHALL clear div_by_zero at edge k.
REQ-022 dividend and divisor SHALL be ignored except at the accepting edge.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for all non-zero divisors.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force IDLE and clear counter, quotient, remainder, busy, done and div_by_zero to 0.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; start is ignored while rst_n=0.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and the default DIV_W.
REQ-027 The trial subtract SHALL be a sub-module trial_subtractor: a DIV_W+1-bit ripple subtractor giving difference and a non-negative flag.
REQ-028 All outputs SHALL be driven directly from registers.

Verification
REQ-029 Normal: start with 13/3 at edge 0 -> busy on edges 1-4, done after edge 4, quotient=4, remainder=1.
REQ-030 Boundaries: 15/1 -> q=15, r=0; 2/9 -> q=0, r=2; 0/5 -> q=0, r=0; 15/15 -> q=1, r=0.
REQ-031 Divide by zero: 7/0 -> done right after the accepting edge, div_by_zero=1, q=4'hF, r=7, busy never high.
REQ-032 Busy start: start with 9/2, then start with 14/7 two cycles later -> second ignored; result q=4, r=1.
REQ-033 Reset mid-run: start 11/2, rst_n=0 at the second RUN edge -> all outputs 0, no done pulse; next start 11/2 -> q=5, r=1.
REQ-034 Exhaustive: all 256 operand pairs checked against REQ-023 and the div-by-zero rule, with done latency checked per pair.
